// File: rtl/bextdep_pkg.sv
// rtl/bextdep_pkg.sv - shared types and constants for the bextdep issue path
package bextdep_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [1:0] MODE_EXT = 2'd0;
    localparam logic [1:0] MODE_DEP = 2'd1;

    // Field order matches the testdata layout: mode, mask, value
    typedef struct packed {
        logic [1:0]              mode;
        logic [XLEN_DEFAULT-1:0] mask;
        logic [XLEN_DEFAULT-1:0] value;
    } bextdep_req_t;

endpackage

// File: rtl/bextdep_fifo.sv
// rtl/bextdep_fifo.sv - generic valid/ready FIFO with occupancy output, no bypass
module bextdep_fifo #(
    parameter int WIDTH = 66,
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push;
    logic             pop;

    // Full/empty come from level alone; in_ready never looks at out_ready
    assign in_ready  = (level_q != LVL_W'(DEPTH));
    assign out_valid = (level_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign level     = level_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Next-state for pointers and occupancy; pointers wrap by natural overflow
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Control state; reset discards queued entries by zeroing pointers and level
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage write; contents are left untouched by reset
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: rtl/bextdep_issue_queue.sv
// rtl/bextdep_issue_queue.sv - request FIFO plus in-flight credit limiter in front of the bextdep unit
module bextdep_issue_queue
    import bextdep_pkg::*;
#(
    parameter int XLEN         = XLEN_DEFAULT,
    parameter int DEPTH        = 4,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_mode,
    input  logic [XLEN-1:0]          in_value,
    input  logic [XLEN-1:0]          in_mask,
    output logic                     din_valid,
    input  logic                     din_ready,
    output logic [1:0]               din_mode,
    output logic [XLEN-1:0]          din_value,
    output logic [XLEN-1:0]          din_mask,
    input  logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               inflight,
    output logic                     err_underflow
);

    localparam int REQ_W = 2 + 2 * XLEN;

    logic [REQ_W-1:0] fifo_in_data;
    logic [REQ_W-1:0] fifo_out_data;
    logic             fifo_out_valid;
    logic             fifo_out_ready;
    logic             credit_ok;
    logic             din_fire;
    logic             out_fire;
    logic [7:0]       inflight_q, inflight_d;
    logic             err_underflow_q, err_underflow_d;

    assign fifo_in_data = {in_mode, in_mask, in_value};
    assign {din_mode, din_mask, din_value} = fifo_out_data;

    // Credit check uses registered inflight only, so a retire frees credit one cycle later
    assign credit_ok      = (inflight_q < 8'(MAX_INFLIGHT));
    assign din_valid      = fifo_out_valid && credit_ok;
    assign fifo_out_ready = din_ready && credit_ok;
    assign din_fire       = din_valid && din_ready;
    assign out_fire       = dout_valid && dout_ready;
    assign inflight       = inflight_q;
    assign err_underflow  = err_underflow_q;

    bextdep_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (fifo_in_data),
        .out_valid (fifo_out_valid),
        .out_ready (fifo_out_ready),
        .out_data  (fifo_out_data),
        .level     (level)
    );

    // In-flight accounting; a retire with nothing outstanding saturates at 0 and flags
    always_comb begin
        inflight_d      = inflight_q;
        err_underflow_d = err_underflow_q;
        case ({din_fire, out_fire})
            2'b10: inflight_d = inflight_q + 8'd1;
            2'b01: begin
                if (inflight_q == 8'd0) begin
                    err_underflow_d = 1'b1;
                end else begin
                    inflight_d = inflight_q - 8'd1;
                end
            end
            default: inflight_d = inflight_q;
        endcase
    end

    // Credit counter and sticky underflow flag
    always_ff @(posedge clock) begin
        if (reset) begin
            inflight_q      <= 8'd0;
            err_underflow_q <= 1'b0;
        end else begin
            inflight_q      <= inflight_d;
            err_underflow_q <= err_underflow_d;
        end
    end

endmodule
